bram_stream_reader: RTL and testbench



---
 rtl/bram_stream_reader.sv | 259 +++++++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Drains a contiguous word range from BRAM port B and presents it as an
// AXI4-Stream master. BRAM read latency is absorbed by a credit-limited skid
// FIFO of RD_LAT+2 entries, so tready backpressure never drops or repeats a word.
// Optional feature macro: READER_LOOP_EN adds the `loop` input; while loop is
// high at the last read of a pass, the next pass restarts from base_addr.
module bram_stream_reader #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
`ifdef READER_LOOP_EN
    input  logic          loop,
`endif
    output logic          busy,
    output logic          done,
    output logic          bram_en,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_dout,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam bit LAT2  = (RD_LAT == 2);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CW_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CW_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LEN_MAX  = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [AW:0]     len_r, len_s, len_in_s, len_cur_s;
    logic [AW-1:0]   base_r, base_s, base_cur_s;
    logic [AW-1:0]   nxt_addr_r, nxt_addr_s, iss_addr_s;
    logic [AW:0]     issued_r, issued_s, iss_cnt_s;
    logic            busy_r, busy_s, done_r, done_s;
    logic            bram_en_r, bram_last_r;
    logic [AW-1:0]   bram_addr_r;
    logic            issue_s, iss_last_s, loop_s;
    logic [CW-1:0]   credit_r, credit_avail_s;
    logic            credit_ok_s;
    logic [1:0]      vld_pipe_r, last_pipe_r;
    logic            push_s, push_last_s, pop_s;
    logic [DW:0]     fifo_mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_n_s;
    logic [CW-1:0]   fifo_cnt_r, fifo_cnt_s, cnt_after_pop_s;
    logic [DW:0]     head_s;
    logic            tvalid_r, tvalid_s, tlast_r;
    logic [DW-1:0]   tdata_r;

    // Circular pointer advance over DEPTH entries (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_MAX) begin
            return {PW{1'b0}};
        end else begin
            return p + PTR_ONE;
        end
    endfunction

`ifdef READER_LOOP_EN
    assign loop_s = loop;
`else
    assign loop_s = 1'b0;
`endif

    assign len_in_s       = (length > LEN_MAX) ? LEN_MAX : length;
    assign pop_s          = tvalid_r & m_axis_tready;
    assign push_s         = LAT2 ? vld_pipe_r[1] : vld_pipe_r[0];
    assign push_last_s    = LAT2 ? last_pipe_r[1] : last_pipe_r[0];
    assign credit_avail_s = credit_r - {{(CW-1){1'b0}}, pop_s};
    assign credit_ok_s    = (credit_avail_s < DEPTH_C);

    // Next-state, issue decision and pass bookkeeping.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        base_s     = base_r;
        nxt_addr_s = nxt_addr_r;
        issued_s   = issued_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        issue_s    = 1'b0;
        iss_addr_s = nxt_addr_r;
        iss_cnt_s  = issued_r + CNT_ONE;
        len_cur_s  = len_r;
        base_cur_s = base_r;
        iss_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len_in_s == CNT_ZERO) begin
                        done_s = 1'b1;
                    end else begin
                        state_s    = ST_RUN;
                        busy_s     = 1'b1;
                        len_s      = len_in_s;
                        base_s     = base_addr;
                        issue_s    = 1'b1;
                        iss_addr_s = base_addr;
                        iss_cnt_s  = CNT_ONE;
                        len_cur_s  = len_in_s;
                        base_cur_s = base_addr;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                // The final pop is the one that empties the outstanding credit.
                if (pop_s && (credit_r == CW_ONE)) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
        if (issue_s) begin
            if (iss_cnt_s == len_cur_s) begin
                iss_last_s = 1'b1;
                if (loop_s) begin
                    nxt_addr_s = base_cur_s;
                    issued_s   = CNT_ZERO;
                end else begin
                    state_s    = ST_DRAIN;
                    nxt_addr_s = iss_addr_s + ADDR_ONE;
                    issued_s   = iss_cnt_s;
                end
            end else begin
                nxt_addr_s = iss_addr_s + ADDR_ONE;
                issued_s   = iss_cnt_s;
            end
        end else begin
            iss_last_s = 1'b0;
        end
    end

    // Control registers, BRAM request outputs and the outstanding-word credit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            len_r       <= CNT_ZERO;
            base_r      <= {AW{1'b0}};
            nxt_addr_r  <= {AW{1'b0}};
            issued_r    <= CNT_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bram_en_r   <= 1'b0;
            bram_last_r <= 1'b0;
            bram_addr_r <= {AW{1'b0}};
            credit_r    <= CW_ZERO;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            base_r      <= base_s;
            nxt_addr_r  <= nxt_addr_s;
            issued_r    <= issued_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            bram_en_r   <= issue_s;
            bram_last_r <= iss_last_s;
            bram_addr_r <= issue_s ? iss_addr_s : bram_addr_r;
            credit_r    <= credit_avail_s + {{(CW-1){1'b0}}, issue_s};
        end
    end

    // Issue-valid shift register marking when bram_dout holds a requested word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_r  <= 2'b00;
            last_pipe_r <= 2'b00;
        end else begin
            vld_pipe_r  <= {vld_pipe_r[0], bram_en_r};
            last_pipe_r <= {last_pipe_r[0], bram_en_r & bram_last_r};
        end
    end

    // FIFO occupancy and next stream head (head holds until it is popped).
    always_comb begin
        rd_ptr_n_s      = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        cnt_after_pop_s = fifo_cnt_r - {{(CW-1){1'b0}}, pop_s};
        fifo_cnt_s      = cnt_after_pop_s + {{(CW-1){1'b0}}, push_s};
        tvalid_s        = (fifo_cnt_s != CW_ZERO);
        if (cnt_after_pop_s != CW_ZERO) begin
            head_s = fifo_mem_r[rd_ptr_n_s];
        end else if (push_s) begin
            head_s = {push_last_s, bram_dout};
        end else begin
            head_s = {1'b0, tdata_r};
        end
    end

    // Skid FIFO storage and registered stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {(DW+1){1'b0}};
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= CW_ZERO;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            tdata_r    <= {DW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {push_last_s, bram_dout};
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            rd_ptr_r   <= rd_ptr_n_s;
            fifo_cnt_r <= fifo_cnt_s;
            tvalid_r   <= tvalid_s;
            tlast_r    <= head_s[DW];
            tdata_r    <= head_s[DW-1:0];
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign bram_en       = bram_en_r;
    assign bram_addr     = bram_addr_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader (AW=10, DW=32, RD_LAT=1) with a behavioural
// BRAM preloaded with word i = 2*i. Table-driven transfers plus hand sequences.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = 10'd0;
    logic [10:0] length = 11'd0;
    logic        busy, done, bram_en;
    logic [9:0]  bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready = 1'b1;
`ifdef READER_LOOP_EN
    logic        loop = 1'b0;
`endif

    logic [31:0] mem [1024];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] len;
        logic [3:0]  rdy;
        logic [31:0] first_d;
        logic [31:0] last_d;
        int          last_hs;
    } vec_t;
    vec_t vecs [6];

    bram_stream_reader #(.AW(10), .DW(32), .RD_LAT(1)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
`ifdef READER_LOOP_EN
        .loop(loop),
`endif
        .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #4 clk = ~clk;

    // One-cycle-latency BRAM read port.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_bram_en"}, {31'd0, bram_en}, 32'd0);
        chk({tag, "_bram_addr"}, {22'd0, bram_addr}, 32'd0);
        chk({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
        chk({tag, "_tlast"}, {31'd0, m_axis_tlast}, 32'd0);
        chk({tag, "_tdata"}, m_axis_tdata, 32'd0);
    endtask

    // Runs one transfer, checking every issue, handshake and the done timing.
    task automatic run_xfer(input logic [9:0] b, input logic [10:0] l, input logic [3:0] pat,
                            input logic [31:0] ef, input logic [31:0] el, input int elh);
        int nw, s, hs, iss, out_max, first_v, last_hs, done_s, done_cnt, budget;
        logic gap, prev_stall, prev_last, rdy;
        logic [31:0] prev_data, first_d, last_d;
        nw = (l > 11'd1024) ? 1024 : int'(l);
        hs = 0; iss = 0; out_max = 0; first_v = -1; last_hs = -1; done_s = -1; done_cnt = 0;
        gap = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = 32'd0;
        first_d = 32'hDEAD_BEEF; last_d = 32'hDEAD_BEEF;
        budget = 4 * nw + 40;
        base_addr = b; length = l; start = 1'b1;
        tick();
        start = 1'b0;
        s = 0;
        while (s < budget && !(done_cnt != 0 && s > done_s + 2)) begin
            rdy = pat[s % 4];
            m_axis_tready = rdy;
            if (nw >= 8 && s == 4) begin
                start = 1'b1; base_addr = ~b; length = 11'd3;
            end else begin
                start = 1'b0;
            end
            if (s == 0) chk("busy_after_start", {31'd0, busy}, 32'd1);
            if (bram_en) begin
                chk("bram_addr", {22'd0, bram_addr}, 32'((int'(b) + iss) % 1024));
                iss++;
            end
            if (iss - hs > out_max) out_max = iss - hs;
            if (!bram_en && iss > 0 && iss < nw) gap = 1'b1;
            if (prev_stall) begin
                chk("hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
                chk("hold_tdata", m_axis_tdata, prev_data);
                chk("hold_tlast", {31'd0, m_axis_tlast}, {31'd0, prev_last});
            end
            if (done) begin
                done_cnt++;
                done_s = s;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (done_cnt != 0 && s > done_s) chk("tvalid_after_done", {31'd0, m_axis_tvalid}, 32'd0);
            if (m_axis_tvalid && first_v < 0) first_v = s;
            if (m_axis_tvalid && rdy) begin
                chk("tdata", m_axis_tdata, 32'(2 * ((int'(b) + hs) % 1024)));
                chk("tlast", {31'd0, m_axis_tlast}, (hs == nw - 1) ? 32'd1 : 32'd0);
                if (hs == 0) first_d = m_axis_tdata;
                last_d = m_axis_tdata;
                last_hs = s;
                hs++;
            end
            prev_stall = m_axis_tvalid && !rdy;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            tick();
            s++;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        chk("word_count", 32'(hs), 32'(nw));
        chk("issue_count", 32'(iss), 32'(nw));
        chk("first_valid_cycle", 32'(first_v), 32'd2);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_after_last", 32'(done_s), 32'(last_hs + 1));
        chk("first_word", first_d, ef);
        chk("last_word", last_d, el);
        chk("credit_max", 32'(out_max), (nw >= 3) ? 32'd3 : 32'(nw));
        chk("en_gap", {31'd0, gap}, (pat != 4'hF) ? 32'd1 : 32'd0);
        if (elh >= 0) chk("last_hs_cycle", 32'(last_hs), 32'(elh));
    endtask

    initial begin
        int hs;
        vecs[0] = '{base: 10'd0,    len: 11'd16,   rdy: 4'b1111, first_d: 32'd0,    last_d: 32'd30,   last_hs: 17};
        vecs[1] = '{base: 10'd1020, len: 11'd8,    rdy: 4'b1111, first_d: 32'd2040, last_d: 32'd6,    last_hs: 9};
        vecs[2] = '{base: 10'd100,  len: 11'd10,   rdy: 4'b1001, first_d: 32'd200,  last_d: 32'd218,  last_hs: -1};
        vecs[3] = '{base: 10'd1023, len: 11'd1,    rdy: 4'b1111, first_d: 32'd2046, last_d: 32'd2046, last_hs: 2};
        vecs[4] = '{base: 10'd0,    len: 11'd1500, rdy: 4'b1111, first_d: 32'd0,    last_d: 32'd2046, last_hs: 1025};
        vecs[5] = '{base: 10'd512,  len: 11'd5,    rdy: 4'b0110, first_d: 32'd1024, last_d: 32'd1032, last_hs: -1};
        for (int i = 0; i < 1024; i++) mem[i] = 32'(2 * i);

        tick(); tick();
        chk_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].rdy, vecs[v].first_d, vecs[v].last_d, vecs[v].last_hs);
            tick();
        end

        // Zero-length start: immediate done, no busy, no stream activity.
        base_addr = 10'd3; length = 11'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("len0_done_after", {31'd0, done}, 32'd0);
            chk("len0_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
            chk("len0_bram_en", {31'd0, bram_en}, 32'd0);
            chk("len0_busy_after", {31'd0, busy}, 32'd0);
        end

        // Reset asserted after 5 words aborts the transfer without done.
        base_addr = 10'd0; length = 11'd16; start = 1'b1; m_axis_tready = 1'b1;
        tick();
        start = 1'b0;
        hs = 0;
        for (int k = 0; k < 40 && hs < 5; k++) begin
            if (m_axis_tvalid) hs++;
            tick();
        end
        chk("abort_words_before_reset", 32'(hs), 32'd5);
        rstn = 1'b0;
        #1;
        chk_reset_outputs("abort");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        rstn = 1'b1;
        tick();
        run_xfer(10'd0, 11'd4, 4'hF, 32'd0, 32'd6, 5);
        tick();

`ifdef READER_LOOP_EN
        begin
            int iss, dn_cnt, dn_s;
            loop = 1'b1; base_addr = 10'd0; length = 11'd4; start = 1'b1;
            tick();
            start = 1'b0;
            hs = 0; iss = 0; dn_cnt = 0; dn_s = 0;
            for (int s = 0; s < 200 && !(dn_cnt != 0 && s > dn_s + 3); s++) begin
                if (bram_en) iss++;
                if (iss >= 13) loop = 1'b0;
                if (done) begin dn_cnt++; dn_s = s; end
                if (m_axis_tvalid) begin
                    chk("loop_tdata", m_axis_tdata, 32'(2 * (hs % 4)));
                    chk("loop_tlast", {31'd0, m_axis_tlast}, (hs % 4 == 3) ? 32'd1 : 32'd0);
                    hs++;
                end
                tick();
            end
            chk("loop_words", 32'(hs), 32'd16);
            chk("loop_done_count", 32'(dn_cnt), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
